othello_cell_plotter: RTL

- Datapath stage directly downstream of the game control FSM.
- Consumes the FSM's draw_cell, plot_empty, place_disk and turn_side commands, plus the move_* keys.
- Owns the 8x8 board contents and the cursor position.
- Streams one pixel per cycle (x, y, colour, plot) to the VGA adapter, painting one cell per command.

---
 rtl/othello_cell_plotter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/othello_cell_plotter.sv
// rtl/othello_cell_plotter.sv - board/cursor owner that paints one 8x8-board cell per command
// as a pixel stream for the VGA adapter.
module othello_cell_plotter #(
  parameter int          CELL_SIZE     = 8,
  parameter int          ORIGIN_X      = 16,
  parameter int          ORIGIN_Y      = 8,
  parameter logic [2:0]  BOARD_COLOUR  = 3'b010,
  parameter logic [2:0]  GRID_COLOUR   = 3'b001,
  parameter logic [2:0]  CURSOR_COLOUR = 3'b100
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       draw_cell,
  input  logic       plot_empty,
  input  logic       place_disk,
  input  logic       turn_side,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       reject,
  output logic [2:0] cur_col,
  output logic [2:0] cur_row
);

  typedef enum logic [1:0] {IDLE, PAINT, DONE} state_t;

  localparam logic [3:0] LAST = 4'(CELL_SIZE - 1);

  state_t      state, state_d;
  logic [1:0]  board [64];
  logic [2:0]  col_q, row_q;
  logic [2:0]  paint_col, paint_row, paint_col_d, paint_row_d;
  logic [3:0]  px, py, px_d, py_d;
  logic        mode_cur, mode_cur_d;
  logic        pending;
  logic        up_q, down_q, left_q, right_q;
  logic        up_e, down_e, left_e, right_e;
  logic        accept, place_req, place_ok, reject_d;
  logic [5:0]  cur_idx;
  logic [1:0]  cell_d;
  logic        edge_pix, plot_d;
  logic [7:0]  x_d;
  logic [6:0]  y_d;
  logic [2:0]  colour_d;

  function automatic logic [1:0] init_cell(input int idx);
    case (idx)
      27, 36:  return 2'b10;
      28, 35:  return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  assign cur_idx = {row_q, col_q};
  assign cur_col = col_q;
  assign cur_row = row_q;
  assign up_e    = move_up    & ~up_q;
  assign down_e  = move_down  & ~down_q;
  assign left_e  = move_left  & ~left_q;
  assign right_e = move_right & ~right_q;

  // Cursor follows key rising edges only, saturating at the board edge.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      up_q <= 1'b0; down_q <= 1'b0; left_q <= 1'b0; right_q <= 1'b0;
      col_q <= 3'd0;
      row_q <= 3'd0;
    end else begin
      up_q    <= move_up;
      down_q  <= move_down;
      left_q  <= move_left;
      right_q <= move_right;
      if (down_e && !up_e && row_q != 3'd7)
        row_q <= row_q + 3'd1;
      else if (up_e && !down_e && row_q != 3'd0)
        row_q <= row_q - 3'd1;
      if (right_e && !left_e && col_q != 3'd7)
        col_q <= col_q + 3'd1;
      else if (left_e && !right_e && col_q != 3'd0)
        col_q <= col_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      for (int i = 0; i < 64; i++) board[i] <= init_cell(i);
    end else if (place_ok) begin
      board[cur_idx] <= {turn_side, ~turn_side};
    end
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    place_ok   = 1'b0;
    reject_d   = 1'b0;
    mode_cur_d = mode_cur;
    place_req  = place_disk | pending;
    case (state)
      IDLE: begin
        if (place_req) begin
          if (board[cur_idx] == 2'b00) begin
            accept     = 1'b1;
            place_ok   = 1'b1;
            mode_cur_d = 1'b0;
          end else begin
            reject_d = 1'b1;
          end
        end else if (plot_empty) begin
          accept     = 1'b1;
          mode_cur_d = 1'b0;
        end else if (draw_cell) begin
          accept     = 1'b1;
          mode_cur_d = 1'b1;
        end
        if (accept) state_d = PAINT;
      end
      PAINT:   if (px == LAST && py == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded with the pixel the next state will show.
  always_comb begin
    px_d        = px;
    py_d        = py;
    paint_col_d = paint_col;
    paint_row_d = paint_row;
    if (accept) begin
      px_d        = 4'd0;
      py_d        = 4'd0;
      paint_col_d = col_q;
      paint_row_d = row_q;
    end else if (state == PAINT) begin
      if (px == LAST) begin
        px_d = 4'd0;
        py_d = py + 4'd1;
      end else begin
        px_d = px + 4'd1;
      end
    end
    cell_d   = place_ok ? {turn_side, ~turn_side} : board[{paint_row_d, paint_col_d}];
    edge_pix = (px_d == 4'd0) || (px_d == LAST) || (py_d == 4'd0) || (py_d == LAST);
    x_d = 8'(9'(ORIGIN_X) + 9'(paint_col_d) * 9'(CELL_SIZE) + 9'(px_d));
    y_d = 7'(9'(ORIGIN_Y) + 9'(paint_row_d) * 9'(CELL_SIZE) + 9'(py_d));
    if (edge_pix)
      colour_d = mode_cur_d ? CURSOR_COLOUR : GRID_COLOUR;
    else begin
      case (cell_d)
        2'b00:   colour_d = BOARD_COLOUR;
        2'b01:   colour_d = 3'b000;
        default: colour_d = 3'b111;
      endcase
    end
    plot_d = (state_d == PAINT);
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      px        <= 4'd0;
      py        <= 4'd0;
      paint_col <= 3'd0;
      paint_row <= 3'd0;
      mode_cur  <= 1'b0;
      pending   <= 1'b0;
      x         <= 8'd0;
      y         <= 7'd0;
      colour    <= 3'd0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reject    <= 1'b0;
    end else begin
      px        <= px_d;
      py        <= py_d;
      paint_col <= paint_col_d;
      paint_row <= paint_row_d;
      mode_cur  <= mode_cur_d;
      if (state != IDLE && place_disk) pending <= 1'b1;
      else if (state == IDLE && place_req) pending <= 1'b0;
      x      <= plot_d ? x_d : 8'd0;
      y      <= plot_d ? y_d : 7'd0;
      colour <= plot_d ? colour_d : 3'd0;
      plot   <= plot_d;
      busy   <= plot_d;
      done   <= (state_d == DONE);
      reject <= reject_d;
    end
  end

endmodule
